// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with single-entry instruction register
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ir_n, ir_pc_n;
    logic        pend, pend_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic        redir_ok, redir_bad;

    assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= 32'h0;
            ir_pc   <= 32'h0;
            pend    <= 1'b0;
            pend_pc <= 32'h0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            ir      <= ir_n;
            ir_pc   <= ir_pc_n;
            pend    <= pend_n;
            pend_pc <= pend_pc_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        ir_pc_n   = ir_pc;
        pend_n    = pend;
        pend_pc_n = pend_pc;
        if (redir_bad) begin
            // A misaligned target wins over everything and abandons any request.
            state_n = S_FAULT;
            ir_pc_n = redirect_pc;
            pend_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_FETCH;
                    if (redir_ok) pc_n = redirect_pc;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redir_ok) begin
                            pc_n   = redirect_pc;
                            pend_n = 1'b0;
                        end else if (pend) begin
                            pc_n   = pend_pc;
                            pend_n = 1'b0;
                        end else begin
                            ir_n    = imem_data;
                            ir_pc_n = pc;
                            pc_n    = pc + 32'd4;
                            state_n = S_HOLD;
                        end
                    end else if (redir_ok) begin
                        // Request stays on the bus; the target is applied when it completes.
                        pend_n    = 1'b1;
                        pend_pc_n = redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (redir_ok) begin
                        pc_n    = redirect_pc;
                        state_n = S_FETCH;
                    end else if (ir_ready) begin
                        state_n = S_FETCH;
                    end
                end
                S_FAULT: begin
                    if (redir_ok) begin
                        pc_n    = redirect_pc;
                        state_n = S_FETCH;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign ir_valid  = (state == S_HOLD);
    assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] req_q[$];
    logic [63:0] ir_q[$];
    logic [31:0] fault_q[$];

    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_ack(input logic [31:0] d, input int lat);
        int n = 0;
        while (!imem_req && n < 20) begin
            cyc();
            n++;
        end
        check("req_seen", {63'h0, imem_req}, 64'h1);
        repeat (lat) cyc();
        imem_ack  = 1'b1;
        imem_data = d;
        cyc();
        imem_ack  = 1'b0;
        imem_data = BAD;
    endtask

    // Monitor: compares each new request, each new ir_valid pulse and each fault update.
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0, prev_fault = 1'b0;
    logic [31:0] prev_irpc = 32'h0;
    always @(negedge clk) begin
        if (imem_req && (!prev_req || prev_ack)) begin
            if (req_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
            end else begin
                check("req_addr", {32'h0, imem_addr}, {32'h0, req_q.pop_front()});
            end
        end
        if (ir_valid && !prev_valid) begin
            if (ir_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_ir_valid: got ir %h pc %h expected none", ir, ir_pc);
            end else begin
                check("ir_word", {ir, ir_pc}, ir_q.pop_front());
            end
        end
        if (fault && (!prev_fault || ir_pc != prev_irpc)) begin
            if (fault_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_fault: got ir_pc %h expected none", ir_pc);
            end else begin
                check("fault_pc", {32'h0, ir_pc}, {32'h0, fault_q.pop_front()});
            end
        end
        prev_ack   = imem_req && imem_ack;
        prev_req   = imem_req;
        prev_valid = ir_valid;
        prev_fault = fault;
        prev_irpc  = ir_pc;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; imem_ack = 1'b0; imem_data = BAD; ir_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) cyc();
        check("rst_req",   {63'h0, imem_req}, 64'h0);
        check("rst_valid", {63'h0, ir_valid}, 64'h0);
        check("rst_fault", {63'h0, fault},    64'h0);
        check("rst_ir",    {32'h0, ir},       64'h0);
        check("rst_ir_pc", {32'h0, ir_pc},    64'h0);

        // Release: one IDLE cycle, then the first fetch at RESET_PC.
        req_q.push_back(32'h0);
        ir_q.push_back({32'h0000_0013, 32'h0});
        rst = 1'b1;
        #4;
        check("idle_no_req", {63'h0, imem_req}, 64'h0);
        cyc();
        check("first_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
        mem_ack(32'h0000_0013, 1);

        // Stalled execute stage: ir held, no request.
        for (int i = 0; i < 5; i++) begin
            check("hold_stable", {ir, ir_pc}, {32'h0000_0013, 32'h0});
            check("hold_req_valid", {62'h0, imem_req, ir_valid}, 64'h1);
            cyc();
        end
        req_q.push_back(32'h4);
        ir_ready = 1'b1; cyc(); ir_ready = 1'b0;
        check("next_addr", {32'h0, imem_addr}, 64'h4);
        ir_q.push_back({32'h0010_0093, 32'h4});
        mem_ack(32'h0010_0093, 0);
        req_q.push_back(32'h8);
        ir_ready = 1'b1; cyc(); ir_ready = 1'b0;

        // Redirect two cycles before the ack of the fetch at 8.
        redirect = 1'b1; redirect_pc = 32'h100; cyc(); redirect = 1'b0;
        check("pend_addr_a", {32'h0, imem_addr}, 64'h8);
        cyc();
        check("pend_addr_b", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h8});
        req_q.push_back(32'h100);
        imem_ack = 1'b1; imem_data = BAD; cyc(); imem_ack = 1'b0;
        check("discard_valid", {63'h0, ir_valid}, 64'h0);
        ir_q.push_back({32'h0000_0033, 32'h100});
        mem_ack(32'h0000_0033, 2);

        // Misaligned redirect from HOLD, FAULT ignores ready/ack, re-fault, recover.
        fault_q.push_back(32'h102);
        redirect = 1'b1; redirect_pc = 32'h102; cyc(); redirect = 1'b0;
        check("fault_set", {61'h0, fault, ir_valid, imem_req}, 64'h4);
        check("fault_ir_pc", {32'h0, ir_pc}, 64'h102);
        ir_ready = 1'b1; imem_ack = 1'b1; cyc(); ir_ready = 1'b0; imem_ack = 1'b0;
        check("fault_sticky", {61'h0, fault, ir_valid, imem_req}, 64'h4);
        fault_q.push_back(32'h207);
        redirect = 1'b1; redirect_pc = 32'h207; cyc(); redirect = 1'b0;
        check("refault_pc", {63'h0, fault}, 64'h1);
        req_q.push_back(32'h200);
        redirect = 1'b1; redirect_pc = 32'h200; cyc(); redirect = 1'b0;
        check("fault_clear", {31'h0, fault, imem_addr}, {31'h0, 1'b0, 32'h200});
        ir_q.push_back({32'h0000_0073, 32'h200});
        mem_ack(32'h0000_0073, 1);

        // Wrap of pc at the top of the address space.
        req_q.push_back(32'hFFFF_FFFC);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; cyc(); redirect = 1'b0;
        ir_q.push_back({32'h0000_0013, 32'hFFFF_FFFC});
        mem_ack(32'h0000_0013, 0);
        req_q.push_back(32'h0);
        ir_ready = 1'b1; cyc(); ir_ready = 1'b0;
        check("pc_wrap", {32'h0, imem_addr}, 64'h0);

        // Two redirects while pending: last one wins.
        redirect = 1'b1; redirect_pc = 32'h300; cyc();
        redirect_pc = 32'h400; cyc(); redirect = 1'b0;
        check("pend2_addr", {32'h0, imem_addr}, 64'h0);
        req_q.push_back(32'h400);
        imem_ack = 1'b1; cyc(); imem_ack = 1'b0;
        check("last_wins", {32'h0, imem_addr}, 64'h400);

        // Redirect concurrent with ack.
        req_q.push_back(32'h500);
        redirect = 1'b1; redirect_pc = 32'h500; imem_ack = 1'b1; cyc();
        redirect = 1'b0; imem_ack = 1'b0;
        check("concurrent", {31'h0, ir_valid, imem_addr}, {31'h0, 1'b0, 32'h500});

        // Reset mid-request, late ack lands in IDLE.
        rst = 1'b0; cyc();
        check("midrst_out", {61'h0, imem_req, ir_valid, fault}, 64'h0);
        req_q.push_back(32'h0);
        rst = 1'b1; imem_ack = 1'b1; imem_data = BAD; cyc(); imem_ack = 1'b0;
        check("restart", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
        ir_q.push_back({32'h0000_0093, 32'h0});
        mem_ack(32'h0000_0093, 1);
        repeat (3) cyc();

        check("req_q_empty",   {32'h0, 32'(req_q.size())},   64'h0);
        check("ir_q_empty",    {32'h0, 32'(ir_q.size())},    64'h0);
        check("fault_q_empty", {32'h0, 32'(fault_q.size())}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address; it must be word-aligned.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port imem_req  output  1  instruction memory read request.
REQ-005 The block SHALL have port imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-006 The block SHALL have port imem_ack  input  1  memory response strobe, one cycle per request.
REQ-007 The block SHALL have port imem_data  input  32  instruction word, valid when imem_ack=1.
REQ-008 The block SHALL have port ir  output  32  held instruction word, driven to the instruction decoder.
REQ-009 The block SHALL have port ir_pc  output  32  address of ir, or the faulting address in FAULT.
REQ-010 The block SHALL have port ir_valid  output  1  ir holds a valid instruction for the execute stage.
REQ-011 The block SHALL have port ir_ready  input  1  execute stage consumes ir this cycle.
REQ-012 The block SHALL have port redirect  input  1  branch/jump/trap redirect strobe.
REQ-013 The block SHALL have port redirect_pc  input  32  redirect target, sampled when redirect=1.
REQ-014 The block SHALL have port fault  output  1  misaligned-fetch fault indication.

Function
REQ-015 The block SHALL implement states IDLE, FETCH, HOLD and FAULT, with all outputs decoded from registered state.
REQ-016 In IDLE the block SHALL move to FETCH on the next cycle.
REQ-017 In FETCH the block SHALL assert imem_req=1 with imem_addr=pc, both held stable until imem_ack.
REQ-018 On imem_ack in FETCH with no pending or concurrent redirect, the block SHALL load ir=imem_data and ir_pc=pc, set pc=pc+4 and enter HOLD.
REQ-019 pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-020 In HOLD the block SHALL assert ir_valid=1 with ir and ir_pc stable, and keep imem_req=0.
REQ-021 In HOLD with ir_ready=1 and redirect=0, the block SHALL enter FETCH, which gives one bubble cycle between consecutive ir_valid pulses.
REQ-022 redirect SHALL take priority over ir_ready and imem_ack in every state.
REQ-023 A redirect with redirect_pc[1:0]!=0 SHALL set ir_pc=redirect_pc, clear ir_valid and enter FAULT; this overrides REQ-024 to REQ-026.
REQ-024 An aligned redirect in HOLD SHALL clear ir_valid next cycle, set pc=redirect_pc and enter FETCH.
REQ-025 An aligned redirect in FETCH before imem_ack SHALL keep imem_req and imem_addr unchanged, latch redirect_pc into a pending register, and set a pending flag.
REQ-026 On imem_ack while the pending flag is set, or concurrent with an aligned redirect, the block SHALL discard imem_data, set pc to the newest redirect target, clear the pending flag and remain in FETCH, issuing a new request on the next cycle.
REQ-027 A later redirect while the pending flag is set SHALL overwrite the pending target; the last one wins.
REQ-028 In FAULT the block SHALL drive fault=1, imem_req=0 and ir_valid=0, ignore ir_ready and imem_ack, and stay there until a redirect.
REQ-029 In FAULT an aligned redirect SHALL clear fault, set pc=redirect_pc and enter FETCH; a misaligned redirect SHALL remain in FAULT with ir_pc updated.
REQ-030 The block SHALL issue at most one outstanding memory request at any time.

Reset
REQ-031 While rst=0 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, ir=0, ir_pc=0 and the pending flag=0.
REQ-032 During reset the outputs SHALL be imem_req=0, ir_valid=0 and fault=0.
REQ-033 Reset asserted mid-request SHALL abandon the request, and a late imem_ack after reset SHALL be ignored in IDLE.
REQ-034 The first imem_req SHALL assert two cycles after rst rises: IDLE, then FETCH.

Verification
REQ-035 Reset release, memory acks 1 cycle after req with 32'h00000013 -> imem_addr=0, then ir=32'h00000013, ir_pc=0, ir_valid=1, next fetch address 4.
REQ-036 ir_ready held 0 for 5 cycles in HOLD -> ir and ir_pc stable, imem_req=0; ir_ready=1 -> FETCH at pc+4.
REQ-037 Redirect to 32'h0000_0100 two cycles before the ack of a fetch at 8 -> imem_addr stays 8 until ack, data discarded, next request at 32'h100, no ir_valid for the discarded word.
REQ-038 redirect with redirect_pc=32'h0000_0102 in HOLD -> fault=1, ir_pc=32'h102, ir_valid=0; later redirect to 32'h200 -> fault=0, fetch at 32'h200.
REQ-039 Redirect to 32'hFFFF_FFFC, ack, ir_ready -> next imem_addr=32'h0000_0000.
REQ-040 rst=0 pulsed while imem_req=1, with an ack arriving in IDLE -> no ir_valid, then restart fetch at RESET_PC.
